// File: rtl/config_acc_pkg.sv
// Shared types and helpers for the precision-configurable accumulator.
package config_acc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } acc_state_e;

  localparam int unsigned DefAccW = 32;
  localparam int unsigned DefLenW = 8;
  // Widest accumulator the lane-split helper can produce.
  localparam int unsigned MaxAccW = 64;

  // Sign-extend a p-bit operand into one acc_w lane (full) or two acc_w/2 lanes (halved).
  // Bits at and above acc_w are returned as zero; callers truncate to their own width.
  function automatic logic [MaxAccW-1:0] lane_split(input logic [MaxAccW-1:0] op,
                                                    input int unsigned       p,
                                                    input int unsigned       acc_w,
                                                    input logic              halved);
    logic [MaxAccW-1:0] res;
    logic [5:0]         src;
    int unsigned        half_w;
    int unsigned        half_p;
    int unsigned        j;
    res    = '0;
    half_w = acc_w / 2;
    half_p = p / 2;
    for (int unsigned i = 0; i < MaxAccW; i++) begin
      src = '0;
      if (i < acc_w) begin
        if (!halved) begin
          src = (i < p) ? 6'(i) : 6'(p - 1);
        end else if (i < half_w) begin
          src = (i < half_p) ? 6'(i) : 6'(half_p - 1);
        end else begin
          j   = i - half_w;
          src = (j < half_p) ? 6'(half_p + j) : 6'(p - 1);
        end
        res[i] = op[src];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/split_acc_adder.sv
// Accumulator adder whose carry between the two halves can be cut for dual-lane operation.
module split_acc_adder
  import config_acc_pkg::*;
#(
  parameter int unsigned ACC_W = DefAccW
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             halved,
  output logic [ACC_W-1:0] sum
);

  localparam int unsigned HalfW = ACC_W / 2;

  logic [HalfW:0]       lo_sum;
  logic [ACC_W-HalfW-1:0] hi_sum;
  logic                 carry;

  // Low lane adds normally; its carry feeds the high lane only in full-precision mode.
  always_comb begin
    lo_sum = {1'b0, a[HalfW-1:0]} + {1'b0, b[HalfW-1:0]};
    carry  = lo_sum[HalfW] & ~halved;
    hi_sum = a[ACC_W-1:HalfW] + b[ACC_W-1:HalfW] + {{(ACC_W-HalfW-1){1'b0}}, carry};
    sum    = {hi_sum, lo_sum[HalfW-1:0]};
  end

endmodule

// File: rtl/config_accumulator.sv
// Streaming block accumulator with full (one lane) or halved (two lane) precision.
module config_accumulator
  import config_acc_pkg::*;
#(
  parameter int unsigned P     = 8,
  parameter int unsigned ACC_W = DefAccW,
  parameter int unsigned LEN_W = DefLenW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halved_precision,
  input  logic [LEN_W-1:0] len,
  input  logic [P-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  acc_state_e       state_q;
  logic [ACC_W-1:0] acc_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] target_q;
  logic             mode_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_data_q;

  logic             ext_mode;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] sum;
  logic [LEN_W-1:0] len_eff;
  logic [LEN_W-1:0] cnt_next;

  // Config is taken live on the first beat, from the latched copy afterwards.
  always_comb begin
    ext_mode = (state_q == StIdle) ? halved_precision : mode_q;
    ext      = ACC_W'(lane_split(MaxAccW'(in_data), P, ACC_W, ext_mode));
    len_eff  = (len == '0) ? LEN_W'(1) : len;
    cnt_next = cnt_q + LEN_W'(1);
  end

  split_acc_adder #(
    .ACC_W (ACC_W)
  ) u_adder (
    .a      (acc_q),
    .b      (ext),
    .halved (mode_q),
    .sum    (sum)
  );

  // Block FSM with beat counter and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      target_q    <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            mode_q   <= halved_precision;
            target_q <= len_eff;
            acc_q    <= ext;
            cnt_q    <= LEN_W'(1);
            if (len_eff == LEN_W'(1)) begin
              state_q     <= StDone;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_data_q  <= ext;
            end else begin
              state_q <= StAccum;
            end
          end
        end
        StAccum: begin
          if (in_valid) begin
            acc_q <= sum;
            cnt_q <= cnt_next;
            if (cnt_next == target_q) begin
              state_q     <= StDone;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_data_q  <= sum;
            end
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_config_accumulator.sv
// Scoreboard bench for config_accumulator: directed scenarios plus randomized blocks.
module tb_config_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halved_precision = 1'b0;
  logic [7:0]  len = 8'd1;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  int          stall_cycles = 0;
  int          stall_cnt = 0;
  bit          rand_ready = 1'b0;

  config_accumulator #(
    .P     (8),
    .ACC_W (32),
    .LEN_W (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .halved_precision (halved_precision),
    .len              (len),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Reference: plain signed sums, wrapped per lane.
  function automatic logic [31:0] model(input bit hv, input logic [7:0] ops[$]);
    longint s;
    int     lo;
    int     hi;
    logic [31:0] r;
    s = 0; lo = 0; hi = 0;
    foreach (ops[i]) begin
      logic [7:0] v;
      logic [3:0] l0;
      logic [3:0] l1;
      v  = ops[i];
      l0 = v[3:0];
      l1 = v[7:4];
      s  += longint'($signed(v));
      lo += int'($signed(l0));
      hi += int'($signed(l1));
    end
    if (hv) r = {hi[15:0], lo[15:0]};
    else    r = s[31:0];
    return r;
  endfunction

  // Downstream ready: optional fixed stall after out_valid rises, then 1 or random.
  always @(posedge clk) begin
    #1;
    if (out_valid) begin
      if (stall_cnt < stall_cycles) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end else begin
      stall_cnt = 0;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops on every handshake, checks output stability under backpressure.
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_out_data", out_data, 32'd0);
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check("hold_out_valid", {31'd0, out_valid}, 32'd1);
        check("hold_out_data", out_data, prev_data);
      end
      if (out_valid) begin
        check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", out_data, 32'hxxxxxxxx);
          end else begin
            check("result", out_data, exp_q.pop_front());
          end
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
    end
  end

  // Present one operand from a negedge; returns at the negedge after it is accepted.
  task automatic drive_beat(input logic [7:0] d, input bit last);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check(last ? "latency_last" : "latency_mid", {31'd0, out_valid}, {31'd0, last});
  endtask

  task automatic send_block(input bit hv, input logic [7:0] lv, input logic [7:0] ops[$],
                            input logic [31:0] expv, input bit chg);
    int n;
    exp_q.push_back(expv);
    halved_precision = hv;
    len = lv;
    for (int i = 0; i < ops.size(); i++) begin
      if (i == 1 && chg) begin
        halved_precision = ~hv;
        len = lv + 8'd3;
      end
      drive_beat(ops[i], i == ops.size() - 1);
    end
    n = 0;
    while (out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_after_handshake", {31'd0, in_ready}, 32'd1);
    check("no_valid_after_handshake", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [7:0] ops[$];
    int         nb;
    bit         hv;
    logic [7:0] lv;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);

    // Full precision wrap-free mix of positive and negative operands.
    ops = {}; ops.push_back(8'h7F); ops.push_back(8'h7F); ops.push_back(8'h80);
    send_block(1'b0, 8'd3, ops, 32'h0000007E, 1'b0);

    // Halved: lane1 +1, lane0 -1 per beat.
    ops = {}; repeat (4) ops.push_back(8'h1F);
    send_block(1'b1, 8'd4, ops, 32'h0004FFFC, 1'b0);

    // Backpressure for 5 cycles.
    stall_cycles = 5;
    ops = {}; ops.push_back(8'h7F); ops.push_back(8'h7F); ops.push_back(8'h80);
    send_block(1'b0, 8'd3, ops, 32'h0000007E, 1'b0);
    stall_cycles = 0;

    // len = 0 behaves as one beat.
    ops = {}; ops.push_back(8'hF6);
    send_block(1'b0, 8'd0, ops, 32'hFFFFFFF6, 1'b0);

    // Config changes mid-block are ignored; the next block picks them up.
    ops = {}; ops.push_back(8'h10); ops.push_back(8'h20);
    send_block(1'b0, 8'd2, ops, 32'h00000030, 1'b1);
    ops = {}; repeat (5) ops.push_back(8'h11);
    send_block(halved_precision, len, ops, 32'h00050005, 1'b0);

    // Reset after 2 of 4 beats: nothing must come out.
    halved_precision = 1'b0;
    len = 8'd4;
    drive_beat(8'h33, 1'b0);
    drive_beat(8'h44, 1'b0);
    rst = 1'b1;
    #1;
    check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("async_rst_out_data", out_data, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ops = {}; ops.push_back(8'h05);
    send_block(1'b0, 8'd1, ops, 32'h00000005, 1'b0);

    // Randomized blocks with random downstream ready and mid-block config noise.
    rand_ready = 1'b1;
    for (int b = 0; b < 40; b++) begin
      hv = 1'($urandom_range(0, 1));
      lv = 8'($urandom_range(0, 6));
      nb = (lv == 8'd0) ? 1 : int'(lv);
      ops = {};
      for (int k = 0; k < nb; k++) ops.push_back(8'($urandom_range(0, 255)));
      send_block(hv, lv, ops, model(hv, ops), 1'($urandom_range(0, 1)));
    end
    rand_ready = 1'b0;

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
